pipeline_hazard_controller: RTL and testbench

Sequencing controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It consumes the decoded control fields produced in ID (RUWr, load indication, register addresses) and keeps its own shadow of the destination registers in EX, MEM and WB. From that state it generates the stage enables, flushes and forwarding selects. It also freezes the pipeline while the data memory is busy and counts stall cycles for performance monitoring.

---
 rtl/pipeline_hazard_controller.sv | 153 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing control for a 5-stage RISC-V pipeline: stage enables,
// flushes, EX operand forwarding selects, memory-wait freeze and stall counting.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_ru_wr,
  input  logic                  id_is_load,
  input  logic                  ex_br_taken,
  input  logic                  dm_req,
  input  logic                  dm_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [PERF_W-1:0]     stall_cycles
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  ru_wr;
    logic                  is_load;
  } stg_t;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t                r_state, w_state_nxt;
  stg_t                  r_ex, r_mem, r_wb;
  logic [REG_ADDR_W-1:0] r_ex_rs1, r_ex_rs2;
  logic                  r_ex_use1, r_ex_use2;
  logic [PERF_W-1:0]     r_stall;
  logic                  w_freeze, w_ld_hit, w_id_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // The release cycle of MEM_WAIT still freezes; advance happens on the next edge.
  always_comb begin
    w_state_nxt = r_state;
    w_freeze    = 1'b0;
    case (r_state)
      RUN: begin
        if (dm_req && !dm_ready) begin
          w_state_nxt = MEM_WAIT;
          w_freeze    = 1'b1;
        end
      end
      MEM_WAIT: begin
        w_freeze = 1'b1;
        if (dm_ready) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_ld_hit = r_ex.valid && r_ex.is_load && r_ex.ru_wr && (r_ex.rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == r_ex.rd)) ||
                     (id_uses_rs2 && (id_rs2 == r_ex.rd)));

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if (w_freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (ex_br_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (id_valid && w_ld_hit) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Writes to x0 are dropped at capture so nothing downstream ever matches on x0.
  assign w_id_wr = id_valid && id_ru_wr && (id_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex      <= '0;
      r_mem     <= '0;
      r_wb      <= '0;
      r_ex_rs1  <= '0;
      r_ex_rs2  <= '0;
      r_ex_use1 <= 1'b0;
      r_ex_use2 <= 1'b0;
    end else if (!w_freeze) begin
      if (id_ex_flush) begin
        r_ex      <= '0;
        r_ex_rs1  <= '0;
        r_ex_rs2  <= '0;
        r_ex_use1 <= 1'b0;
        r_ex_use2 <= 1'b0;
      end else begin
        r_ex      <= '{valid: id_valid, rd: id_rd, ru_wr: w_id_wr,
                       is_load: id_valid && id_is_load};
        r_ex_rs1  <= id_rs1;
        r_ex_rs2  <= id_rs2;
        r_ex_use1 <= id_valid && id_uses_rs1;
        r_ex_use2 <= id_valid && id_uses_rs2;
      end
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  // MEM wins over WB; a load still in MEM has no data to forward yet.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (r_mem.ru_wr && !r_mem.is_load && (r_mem.rd == rs)) sel = 2'b10;
      else if (r_wb.ru_wr && (r_wb.rd == rs))                 sel = 2'b01;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_sel(r_ex_rs1);
  assign fwd_b = fwd_sel(r_ex_rs2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_stall <= '0;
    else if (!pc_en && r_stall != '1) r_stall <= r_stall + 1'b1;
  end

  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Table-driven bench for pipeline_hazard_controller; expected outputs are queued
// when a vector is driven and compared when the outputs are sampled.
module tb_pipeline_hazard_controller;

  localparam int PW = 3;
  localparam logic [6:0] NRM = 7'b1101011;
  localparam logic [6:0] LDU = 7'b0001111;
  localparam logic [6:0] BRF = 7'b1111111;
  localparam logic [6:0] FRZ = 7'b0000000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_ru_wr, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic ex_br_taken, dm_req, dm_ready;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic [1:0] fwd_a, fwd_b;
  logic [PW-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.REG_ADDR_W(5), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_ru_wr(id_ru_wr), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
    .dm_req(dm_req), .dm_ready(dm_ready), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cycles(stall_cycles)
  );

  typedef struct {
    string      nm;
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr, ld, br, req, rdy;
    logic [6:0] ctrl;
    logic [1:0] fa, fb;
  } vec_t;

  typedef struct {
    string      nm;
    logic [6:0] ctrl;
    logic [1:0] fa, fb;
    logic [PW-1:0] sc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  logic [PW-1:0] sc_model;
  int n_vec = 0, n_miss = 0;

  task automatic t(input string nm, input logic v, input logic [4:0] rs1, input logic u1,
                   input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                   input logic wr, input logic ld, input logic br, input logic req,
                   input logic rdy, input logic [6:0] ctrl, input logic [1:0] fa,
                   input logic [1:0] fb);
    vec_t x;
    x.nm = nm; x.v = v; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2; x.rd = rd;
    x.wr = wr; x.ld = ld; x.br = br; x.req = req; x.rdy = rdy;
    x.ctrl = ctrl; x.fa = fa; x.fb = fb;
    tbl.push_back(x);
  endtask

  task automatic idle(input string nm, input logic br, input logic req, input logic rdy,
                      input logic [6:0] ctrl, input logic [1:0] fa, input logic [1:0] fb);
    t(nm, 0, 0, 0, 0, 0, 0, 0, 0, br, req, rdy, ctrl, fa, fb);
  endtask

  task automatic drive(input vec_t x);
    exp_t e;
    id_valid = x.v; id_rs1 = x.rs1; id_uses_rs1 = x.u1; id_rs2 = x.rs2;
    id_uses_rs2 = x.u2; id_rd = x.rd; id_ru_wr = x.wr; id_is_load = x.ld;
    ex_br_taken = x.br; dm_req = x.req; dm_ready = x.rdy;
    e.nm = x.nm; e.ctrl = x.ctrl; e.fa = x.fa; e.fb = x.fb; e.sc = sc_model;
    sb.push_back(e);
    if (!x.ctrl[6] && sc_model != '1) sc_model = sc_model + 1'b1;
  endtask

  task automatic check();
    exp_t e;
    logic [6:0] c;
    if (sb.size() == 0) begin
      n_vec++; n_miss++;
      $display("FAIL scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    c = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
    n_vec++;
    if (c !== e.ctrl || fwd_a !== e.fa || fwd_b !== e.fb || stall_cycles !== e.sc) begin
      n_miss++;
      $display("FAIL %s: got ctrl=%b fa=%b fb=%b sc=%0d, want ctrl=%b fa=%b fb=%b sc=%0d",
               e.nm, c, fwd_a, fwd_b, stall_cycles, e.ctrl, e.fa, e.fb, e.sc);
    end
  endtask

  task automatic step(input vec_t x);
    @(posedge clk); #1;
    drive(x);
    @(negedge clk);
    check();
  endtask

  initial begin
    vec_t iv;
    iv = '{nm: "reset", v: 0, rs1: 0, u1: 0, rs2: 0, u2: 0, rd: 0, wr: 0, ld: 0,
           br: 0, req: 0, rdy: 0, ctrl: NRM, fa: 2'b00, fb: 2'b00};
    sc_model = '0;
    drive(iv);
    #2 check();
    #6 rst_n = 1'b1;

    // ALU forwarding: back-to-back, one NOP apart, operand B, MEM-over-WB priority
    t("add_x5",      1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, NRM, 0, 0);
    t("sub_id",      1, 5, 1, 3, 1, 6, 1, 0, 0, 0, 0, NRM, 0, 0);
    idle("sub_ex_mem", 0, 0, 0, NRM, 2'b10, 2'b00);
    idle("pad0",       0, 0, 0, NRM, 0, 0);
    t("add_x5_b",    1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, NRM, 0, 0);
    idle("nop",        0, 0, 0, NRM, 0, 0);
    t("sub_id_b",    1, 5, 1, 3, 1, 6, 1, 0, 0, 0, 0, NRM, 0, 0);
    idle("sub_ex_wb",  0, 0, 0, NRM, 2'b01, 2'b00);
    t("add_rs2_x6",  1, 2, 1, 6, 1, 8, 1, 0, 0, 0, 0, NRM, 0, 0);
    idle("fwd_b_wb",   0, 0, 0, NRM, 2'b00, 2'b01);
    t("add_x9_a",    1, 1, 1, 1, 1, 9, 1, 0, 0, 0, 0, NRM, 0, 0);
    t("add_x9_b",    1, 2, 1, 2, 1, 9, 1, 0, 0, 0, 0, NRM, 0, 0);
    t("use_x9",      1, 9, 1, 9, 1, 10, 1, 0, 0, 0, 0, NRM, 0, 0);
    idle("prio_mem",   0, 0, 0, NRM, 2'b10, 2'b10);
    // Load-use: one bubble then WB forward
    t("lw_x5",       1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, NRM, 0, 0);
    t("ldu_stall",   1, 5, 1, 2, 1, 6, 1, 0, 0, 0, 0, LDU, 0, 0);
    t("ldu_reissue", 1, 5, 1, 2, 1, 6, 1, 0, 0, 0, 0, NRM, 0, 0);
    idle("ldu_fwd_wb", 0, 0, 0, NRM, 2'b01, 2'b00);
    idle("pad1",       0, 0, 0, NRM, 0, 0);
    // Load to x0 never stalls or forwards
    t("lw_x0",       1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, NRM, 0, 0);
    t("use_x0",      1, 0, 1, 2, 1, 6, 1, 0, 0, 0, 0, NRM, 0, 0);
    idle("x0_ex",      0, 0, 0, NRM, 0, 0);
    // Load in MEM with a non-using consumer: no MEM forward
    t("lw_x5_c",     1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, NRM, 0, 0);
    t("nouse_x5",    1, 5, 0, 5, 0, 7, 1, 0, 0, 0, 0, NRM, 0, 0);
    idle("ld_in_mem",  0, 0, 0, NRM, 0, 0);
    idle("pad2",       0, 0, 0, NRM, 0, 0);
    // Branch wins over load-use
    t("lw_x5_d",     1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, NRM, 0, 0);
    t("br_ldu",      1, 5, 1, 2, 1, 6, 1, 0, 1, 0, 0, BRF, 0, 0);
    idle("after_br",   0, 0, 0, NRM, 0, 0);
    idle("pad3",       0, 0, 0, NRM, 0, 0);
    // Memory wait with a pending branch: 4 frozen cycles, flush after release
    t("frz0",        1, 1, 1, 2, 1, 5, 1, 0, 0, 1, 0, FRZ, 0, 0);
    t("frz1_br",     1, 1, 1, 2, 1, 5, 1, 0, 1, 1, 0, FRZ, 0, 0);
    t("frz2_br",     1, 1, 1, 2, 1, 5, 1, 0, 1, 1, 0, FRZ, 0, 0);
    t("frz_release", 1, 1, 1, 2, 1, 5, 1, 0, 1, 1, 1, FRZ, 0, 0);
    t("br_after",    1, 1, 1, 2, 1, 5, 1, 0, 1, 0, 0, BRF, 0, 0);
    idle("post_br",    0, 0, 0, NRM, 0, 0);
    idle("req_rdy",    0, 1, 1, NRM, 0, 0);
    // Counter saturation (3-bit instance)
    idle("sat0",       0, 1, 0, FRZ, 0, 0);
    idle("sat1",       0, 1, 0, FRZ, 0, 0);
    idle("sat2",       0, 1, 0, FRZ, 0, 0);
    idle("sat3",       0, 1, 1, FRZ, 0, 0);
    idle("sat_hold",   0, 0, 0, NRM, 0, 0);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Asynchronous reset in the middle of a memory wait
    tbl.delete();
    t("pre_add_x3",  1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, NRM, 0, 0);
    idle("pre_frz0",   0, 1, 0, FRZ, 0, 0);
    idle("pre_frz1",   0, 1, 0, FRZ, 0, 0);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    #1 rst_n = 1'b0;
    sc_model = '0;
    iv.nm = "mid_wait_reset";
    drive(iv);
    #1 check();
    #1 rst_n = 1'b1;

    tbl.delete();
    t("post_use_x3", 1, 3, 1, 3, 1, 6, 1, 0, 0, 0, 0, NRM, 0, 0);
    idle("post_nofwd", 0, 0, 0, NRM, 0, 0);
    idle("post_idle",  0, 0, 0, NRM, 0, 0);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    if (sb.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL scoreboard_leftover: %0d entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
